// File: rtl/i2c_master_pkg.sv
// Shared types and default constants for the I2C master line-driving path.
package i2c_master_pkg;

  // Drive sources for the default three-source build; DS_IDLE doubles as the
  // first out-of-range select value, which the line driver treats as idle.
  typedef enum logic [1:0] {
    DS_START_STOP = 2'd0,
    DS_TX         = 2'd1,
    DS_RX         = 2'd2,
    DS_IDLE       = 2'd3
  } DriveSelectType;

  typedef enum logic [1:0] {
    LD_IDLE   = 2'd0,
    LD_GUARD  = 2'd1,
    LD_ACTIVE = 2'd2
  } LineDrvStateType;

  localparam int LD_NUM_SRC      = 3;
  localparam int LD_GUARD_CYCLES = 4;
  localparam int LD_SYNC_STAGES  = 2;

endpackage

// File: rtl/i2c_sync.sv
// N-stage synchroniser for a raw pad input; resets to 1 (released line).
// Latency STAGES clocks, no backpressure.
module i2c_sync
  import i2c_master_pkg::*;
#(
  parameter int STAGES = LD_SYNC_STAGES
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr <= '1;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/i2c_line_driver.sv
// Registered, glitch-guarded SDA/SCL source mux with pad synchronisers, stretch and arbitration-loss detect.
// Outputs lag the selected source by one clock; a selection change freezes the lines for GUARD_CYCLES clocks.
module i2c_line_driver
  import i2c_master_pkg::*;
#(
  parameter int NUM_SRC      = LD_NUM_SRC,
  parameter int SEL_W        = $clog2(NUM_SRC),
  parameter int SYNC_STAGES  = LD_SYNC_STAGES,
  parameter int GUARD_CYCLES = LD_GUARD_CYCLES
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel,
  input  logic [NUM_SRC-1:0] src_sda,
  input  logic [NUM_SRC-1:0] src_scl,
  input  logic               sda_in,
  input  logic               scl_in,
  input  logic               arb_clear,
  output logic               sda_out,
  output logic               scl_out,
  output logic               sda_sync,
  output logic               scl_sync,
  output logic               switching,
  output logic               stretch,
  output logic               arb_lost
);

  localparam int               CNT_W     = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [SEL_W:0]   NUM_SRC_W = (SEL_W + 1)'(NUM_SRC);

  LineDrvStateType  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W:0]   req_q, req_d;
  logic [SEL_W:0]   req, cur;
  logic             req_act;
  logic             sda_d, scl_d;
  logic             arb_det;

  i2c_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (sda_in),
    .q     (sda_sync)
  );

  i2c_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (scl_in),
    .q     (scl_sync)
  );

  // Out-of-range selects behave exactly like sel_valid=0.
  assign req_act = sel_valid && ({1'b0, sel} < NUM_SRC_W);
  assign req     = {req_act, sel};
  assign cur     = {state_q == LD_ACTIVE, cur_sel_q};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= LD_IDLE;
      cnt_q     <= '0;
      cur_sel_q <= '0;
      req_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
      req_q     <= req_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_sel_d = cur_sel_q;
    req_d     = req_q;
    unique case (state_q)
      LD_IDLE: begin
        if (req_act) begin
          state_d = LD_GUARD;
          cnt_d   = CNT_LOAD;
          req_d   = req;
        end
      end
      LD_ACTIVE: begin
        if (req != cur) begin
          state_d = LD_GUARD;
          cnt_d   = CNT_LOAD;
          req_d   = req;
        end
      end
      LD_GUARD: begin
        // Any request movement restarts the freeze so the new source only
        // goes live after a full quiet window.
        if (req != req_q) begin
          cnt_d = CNT_LOAD;
          req_d = req;
        end else if (cnt_q == '0) begin
          if (req_act) begin
            state_d   = LD_ACTIVE;
            cur_sel_d = sel;
          end else begin
            state_d = LD_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_comb begin
    sda_d = sda_out;
    scl_d = scl_out;
    if (arb_lost || state_q == LD_IDLE) begin
      sda_d = 1'b1;
      scl_d = 1'b1;
    end else if (state_q == LD_ACTIVE) begin
      sda_d = src_sda[cur_sel_q];
      scl_d = src_scl[cur_sel_q];
    end
  end

  // We release SDA with SCL high, yet the bus shows SDA low: another master owns it.
  assign arb_det = (state_q == LD_ACTIVE) && sda_out && scl_out && scl_sync && !sda_sync;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sda_out  <= 1'b1;
      scl_out  <= 1'b1;
      stretch  <= 1'b0;
      arb_lost <= 1'b0;
    end else begin
      sda_out  <= sda_d;
      scl_out  <= scl_d;
      stretch  <= scl_out && !scl_sync;
      arb_lost <= arb_det || (arb_lost && !arb_clear);
    end
  end

  assign switching = (state_q == LD_GUARD);

endmodule

// File: tb/tb_i2c_line_driver.sv
// Directed and randomized bench for i2c_line_driver against a cycle-level behavioural model.
module tb_i2c_line_driver;

  localparam int NUM_SRC      = 3;
  localparam int SEL_W        = 2;
  localparam int SYNC_STAGES  = 2;
  localparam int GUARD_CYCLES = 4;

  logic               clk       = 1'b0;
  logic               n_rst     = 1'b1;
  logic               sel_valid = 1'b0;
  logic [SEL_W-1:0]   sel       = '0;
  logic [NUM_SRC-1:0] src_sda   = '1;
  logic [NUM_SRC-1:0] src_scl   = '1;
  logic               sda_in    = 1'b1;
  logic               scl_in    = 1'b1;
  logic               arb_clear = 1'b0;
  logic sda_out, scl_out, sda_sync, scl_sync, switching, stretch, arb_lost;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_line_driver #(
    .NUM_SRC      (NUM_SRC),
    .SEL_W        (SEL_W),
    .SYNC_STAGES  (SYNC_STAGES),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .sel_valid (sel_valid),
    .sel       (sel),
    .src_sda   (src_sda),
    .src_scl   (src_scl),
    .sda_in    (sda_in),
    .scl_in    (scl_in),
    .arb_clear (arb_clear),
    .sda_out   (sda_out),
    .scl_out   (scl_out),
    .sda_sync  (sda_sync),
    .scl_sync  (scl_sync),
    .switching (switching),
    .stretch   (stretch),
    .arb_lost  (arb_lost)
  );

  // Reference model: mode 0 = lines released, 1 = frozen, 2 = driving m_cur.
  // m_left counts the freeze cycles still owed; m_req is the request last seen (valid*4 + sel).
  int   m_mode, m_left, m_cur, m_req;
  logic m_sda, m_scl, m_arb, m_str;
  logic q_sda[$];
  logic q_scl[$];

  task automatic m_reset();
    m_mode = 0; m_left = 0; m_cur = 0; m_req = 0;
    m_sda = 1'b1; m_scl = 1'b1; m_arb = 1'b0; m_str = 1'b0;
    q_sda.delete();
    q_scl.delete();
    for (int i = 0; i < SYNC_STAGES; i++) begin
      q_sda.push_back(1'b1);
      q_scl.push_back(1'b1);
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sda_out"},   sda_out,   m_sda);
    chk({tag, ".scl_out"},   scl_out,   m_scl);
    chk({tag, ".sda_sync"},  sda_sync,  q_sda[0]);
    chk({tag, ".scl_sync"},  scl_sync,  q_scl[0]);
    chk({tag, ".switching"}, switching, logic'(m_mode == 1));
    chk({tag, ".stretch"},   stretch,   m_str);
    chk({tag, ".arb_lost"},  arb_lost,  m_arb);
  endtask

  // One clock: evaluate the model on the pre-edge inputs, then compare #1 after the edge.
  task automatic tick();
    logic live, s_sda, s_scl, act, det, n_sda, n_scl, n_arb, n_str, in_sda, in_scl;
    int   req, n_mode, n_left, n_cur, n_req;
    live   = n_rst;
    s_sda  = q_sda[0];
    s_scl  = q_scl[0];
    in_sda = sda_in;
    in_scl = scl_in;
    act    = sel_valid && (int'(sel) < NUM_SRC);
    req    = act ? 4 + int'(sel) : int'(sel);
    det    = (m_mode == 2) && m_sda && m_scl && s_scl && !s_sda;
    n_str  = m_scl && !s_scl;
    if (m_arb || m_mode == 0) begin
      n_sda = 1'b1; n_scl = 1'b1;
    end else if (m_mode == 2) begin
      n_sda = src_sda[m_cur]; n_scl = src_scl[m_cur];
    end else begin
      n_sda = m_sda; n_scl = m_scl;
    end
    n_arb  = det || (m_arb && !arb_clear);
    n_mode = m_mode; n_left = m_left; n_cur = m_cur; n_req = m_req;
    if (m_mode == 0) begin
      if (act) begin n_mode = 1; n_left = GUARD_CYCLES; n_req = req; end
    end else if (m_mode == 2) begin
      if (req != 4 + m_cur) begin n_mode = 1; n_left = GUARD_CYCLES; n_req = req; end
    end else begin
      if (req != m_req) begin
        n_left = GUARD_CYCLES; n_req = req;
      end else if (m_left == 1) begin
        n_mode = act ? 2 : 0;
        if (act) n_cur = int'(sel);
      end else begin
        n_left = m_left - 1;
      end
    end
    @(posedge clk);
    #1;
    if (live && n_rst) begin
      m_mode = n_mode; m_left = n_left; m_cur = n_cur; m_req = n_req;
      m_sda = n_sda; m_scl = n_scl; m_arb = n_arb; m_str = n_str;
      q_sda.push_back(in_sda); void'(q_sda.pop_front());
      q_scl.push_back(in_scl); void'(q_scl.pop_front());
    end else begin
      m_reset();
    end
  endtask

  task automatic step(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check_all(tag);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int sw_cnt, arb_at, str_cnt;
    logic saw_zero;

    // Reset held: outputs stay released regardless of sources and pads.
    m_reset();
    #2 n_rst = 1'b0;
    #1 check_all("reset_async");
    for (int i = 0; i < 4; i++) begin
      src_sda = 3'($urandom); src_scl = 3'($urandom);
      sda_in = 1'($urandom); scl_in = 1'($urandom);
      sel_valid = 1'($urandom); sel = 2'($urandom);
      tick();
      check_all("reset_hold");
    end
    n_rst = 1'b1; sel_valid = 1'b0; sda_in = 1'b1; scl_in = 1'b1;
    step(4, "idle");

    // Select source 2: exactly GUARD_CYCLES frozen, then track src[2].
    sel_valid = 1'b1; sel = 2'd2;
    sw_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      src_sda = 3'($urandom); src_scl = 3'($urandom);
      tick(); check_all("sel2");
      if (switching === 1'b1) sw_cnt++;
    end
    chk_int("sel2_guard_len", sw_cnt, GUARD_CYCLES);

    // Switch to source 0.
    sel = 2'd0;
    sw_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      src_sda = 3'($urandom); src_scl = 3'($urandom);
      tick(); check_all("sel0");
      if (switching === 1'b1) sw_cnt++;
    end
    chk_int("sel0_guard_len", sw_cnt, GUARD_CYCLES);

    // Guard restart 2 -> 1 -> 0; source 1 (the only one driving 0) must never appear.
    src_sda = 3'b101; src_scl = 3'b101;
    sel = 2'd2;
    step(10, "restart_pre");
    sel = 2'd1;
    sw_cnt = 0; saw_zero = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) sel = 2'd0;
      tick(); check_all("restart");
      if (switching === 1'b1) sw_cnt++;
      if (sda_out !== 1'b1 || scl_out !== 1'b1) saw_zero = 1'b1;
    end
    chk_int("restart_guard_len", sw_cnt, 2 + GUARD_CYCLES);
    chk("restart_src1_never_driven", saw_zero, 1'b0);

    // Arbitration loss: we release SDA, the bus holds it low.
    src_sda = 3'b111; src_scl = 3'b111;
    step(2, "arb_pre");
    sda_in = 1'b0; scl_in = 1'b1;
    arb_at = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(); check_all("arb_wait");
      if (arb_lost === 1'b1 && arb_at == 0) arb_at = i;
    end
    chk_int("arb_latency", arb_at, SYNC_STAGES + 1);
    src_sda = 3'b000; src_scl = 3'b000;
    step(3, "arb_forced");
    chk("arb_forced_sda", sda_out, 1'b1);
    chk("arb_forced_scl", scl_out, 1'b1);
    arb_clear = 1'b1;
    step(2, "arb_clear_vs_detect");
    chk("arb_set_wins", arb_lost, 1'b1);
    arb_clear = 1'b0; sda_in = 1'b1;
    step(4, "arb_released");
    arb_clear = 1'b1;
    step(1, "arb_clear");
    chk("arb_cleared", arb_lost, 1'b0);
    arb_clear = 1'b0;
    step(3, "arb_post");

    // Stretch: drive SCL released while the pad is held low for 10 cycles.
    src_sda = 3'b111; src_scl = 3'b111;
    step(3, "stretch_pre");
    str_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      scl_in = (i < 10) ? 1'b0 : 1'b1;
      tick(); check_all("stretch");
      if (stretch === 1'b1) str_cnt++;
    end
    chk_int("stretch_len", str_cnt, 10);

    // Out-of-range select behaves as idle.
    src_sda = 3'b000; src_scl = 3'b000;
    step(3, "invalid_pre");
    sel = 2'd3;
    step(8, "invalid");
    chk("invalid_sda", sda_out, 1'b1);
    chk("invalid_scl", scl_out, 1'b1);
    chk("invalid_switching", switching, 1'b0);

    // Asynchronous reset in the middle of a guard window.
    sel = 2'd0;
    step(8, "mid_pre");
    sel = 2'd2;
    step(2, "mid_guard");
    #2 n_rst = 1'b0;
    #1 m_reset();
    chk("async_rst_sda", sda_out, 1'b1);
    chk("async_rst_scl", scl_out, 1'b1);
    chk("async_rst_switching", switching, 1'b0);
    step(2, "mid_rst_hold");
    n_rst = 1'b1; sel = 2'd1;
    sw_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); check_all("post_rst");
      if (switching === 1'b1) sw_cnt++;
    end
    chk_int("post_rst_guard_len", sw_cnt, GUARD_CYCLES);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) begin
        sel_valid = 1'($urandom_range(3) != 0);
        sel = 2'($urandom_range(3));
      end
      src_sda = 3'($urandom); src_scl = 3'($urandom);
      sda_in = 1'($urandom_range(9) != 0);
      scl_in = 1'($urandom_range(9) != 0);
      arb_clear = 1'($urandom_range(3) == 0);
      tick(); check_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
